// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO. Buffers bursty producer data for a consumer
//   in the same clock domain. Provides full/empty, programmable almost-full and
//   almost-empty thresholds, an occupancy count and one-cycle overflow/underflow
//   pulses for rejected requests.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through mode
//   (dout shows the head word combinationally, rd pops it). Without the macro,
//   dout is registered and a read has one clock of latency.
//
// Parameters
//   WIDTH      data word width in bits (>=1)
//   DEPTH      number of entries, power of two, >=4
//   AFULL_TH   almost_full  when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   wr, din       write request and data, sampled at posedge clk
//   rd            read request, sampled at posedge clk
//   dout          read data
//   full, empty   count == DEPTH / count == 0 (registered)
//   almost_full   count >= AFULL_TH (registered)
//   almost_empty  count <= AEMPTY_TH (registered)
//   count         occupancy 0..DEPTH
//   overflow      one-cycle pulse: write rejected
//   underflow     one-cycle pulse: read rejected
//   wrptr, rdptr  next write / read address
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    output logic [AW-1:0]    wrptr,
    output logic [AW-1:0]    rdptr
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_ok;
    logic             wr_ok;
    logic [AW:0]      count_nxt;

    // A write into a full FIFO is allowed only when a read frees a slot in the
    // same cycle; a read from an empty FIFO is always rejected.
    always_comb begin
        rd_ok     = rd & ~empty;
        wr_ok     = wr & (~full | rd_ok);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Control state: pointers, occupancy, flags and error pulses. Flags are
    // computed from the next count so they change on the same edge as count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr        <= '0;
            rdptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wrptr <= wrptr + AW'(1);
            end
            if (rd_ok) begin
                rdptr <= rdptr + AW'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == FULL_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
            overflow     <= wr & ~wr_ok;
            underflow    <= rd & ~rd_ok;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wrptr] <= din;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; zero while nothing is stored.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[rdptr];
        end
    end
`else
    // Registered read port; holds its last value when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[rdptr];
        end
    end
`endif

endmodule
